uart_cmd_deframer: RTL and testbench
====================================

Name: uart_cmd_deframer

Overview:
- Sits between the 12 MHz UART receiver and the pump-probe parameter registers.
- Assembles the 5-byte host command frame: 4 data bytes, LSB first, then 1 control byte.
- Computes the 8-bit byte-sum checksum and presents a single validated command word downstream with a valid/ready handshake.
- Adds inter-byte timeout resynchronisation and error flagging, so a dropped byte can never permanently misalign framing.

Parameters:
- TIMEOUT_CYCLES, 120000, max idle clk cycles between bytes of one frame (10 ms at 12 MHz) before the partial frame is discarded.
- DATA_BYTES, 4, number of data bytes per frame; cmd_data width = 8*DATA_BYTES.

Ports:
- clk  in  1  12 MHz base clock
- reset  in  1  asynchronous, active-high reset
- received  in  1  UART byte-received flag (may stay high >1 cycle)
- rx_byte  in  8  UART received byte, valid while received high
- recv_error  in  1  UART framing error strobe
- cmd_valid  out  1  command word available
- cmd_ready  in  1  downstream accepts command
- cmd_code  out  8  control byte (0=delay, 1=period, 2=pump, 3=probe, 4=toggle pump, 5=att, 6=read test)
- cmd_data  out  32  data word, byte0 in [7:0]
- cmd_check  out  8  sum of the 4 data bytes mod 256
- frame_err  out  1  one-cycle pulse: timeout, recv_error mid-frame, or overrun
- transmit  out  1  UART transmit request (echo only)
- tx_byte  out  8  byte to transmit (echo only)
- is_transmitting  in  1  UART transmit busy

Behaviour:
- Reset values: cmd_valid=0, cmd_code=0, cmd_data=0, cmd_check=0, frame_err=0, transmit=0, tx_byte=0; state=COLLECT; byte_idx=0; timeout counter=0.
- Byte strobe: byte_stb = received & ~received_d, where received_d is registered. A level held for N cycles counts as one byte.
- COLLECT:
  - On byte_stb with byte_idx<DATA_BYTES: store rx_byte at [8*byte_idx +: 8]; add it to the running sum; byte_idx++.
  - On byte_stb with byte_idx==DATA_BYTES: latch cmd_code=rx_byte and cmd_check=sum; set cmd_valid=1 on the next cycle (1-cycle latency after the control-byte strobe); clear byte_idx and sum; go to HOLD.
- HOLD:
  - cmd_valid stays high with cmd_code/cmd_data/cmd_check stable until cmd_valid&cmd_ready.
  - On that handshake cycle: cmd_valid=0 next cycle; go to ECHO if enabled, else COLLECT.
- Timeout counter:
  - Clears on every byte_stb; counts only while byte_idx!=0 in COLLECT; saturates.
  - Reaching TIMEOUT_CYCLES-1: byte_idx=0, sum=0, frame_err pulse; stay in COLLECT.
- recv_error:
  - In COLLECT with byte_idx!=0: discard the partial frame, frame_err pulse.
  - With byte_idx==0: ignored, no pulse.
- Overrun: byte_stb while in HOLD or ECHO drops the byte and pulses frame_err. Held command and byte_idx are unchanged.
- Simultaneous events:
  - byte_stb and timeout expiry in the same cycle: the byte wins and the counter clears.
  - recv_error and byte_stb in the same cycle: error wins and the byte is dropped.
- Arithmetic: checksum is an 8-bit wrapping add; no carry retained.
- Reset asserted mid-frame or mid-HOLD: all state returns to reset values immediately; no partial command is ever emitted.

Optional Feature:
- Macro: CMD_ECHO_EN.
- Defined:
  - After the HOLD handshake, enter ECHO.
  - Wait for ~is_transmitting, then assert transmit for exactly 1 cycle with tx_byte=cmd_check.
  - Wait for is_transmitting to rise and then fall, then return to COLLECT.
- Undefined: ECHO state absent; transmit and tx_byte tied to 0; is_transmitting unused.

Decomposition:
- Shared package pump_probe_pkg holds:
  - CONT_* control-code constants 0..6;
  - FRAME_LEN=5;
  - state enum {COLLECT, HOLD, ECHO}.
- One natural sub-module: uart_byte_timeout, the saturating idle counter with clear/enable and an expiry strobe.

Test Plan:
- Frame 0x10,0x27,0x00,0x00,0x00 -> cmd_valid with cmd_data=0x00002710, cmd_code=0x00, cmd_check=0x37; held until cmd_ready.
- Frame 0xFF,0xFF,0xFF,0xFF,0x05 -> cmd_data=0xFFFFFFFF, cmd_code=0x05, cmd_check=0xFC (wrap).
- Two bytes, then idle TIMEOUT_CYCLES -> frame_err pulse. A following full frame 0x01,0,0,0,0x04 then decodes correctly with cmd_data=1, code=4.
- received held high 20 cycles per byte -> each byte counted once; frame decodes identically to the single-cycle-strobe case.
- cmd_ready=0 and a 6th byte arrives in HOLD -> frame_err pulse; held command unchanged; after cmd_ready the next frame decodes from byte 0.
- Reset asserted after 3 bytes -> outputs at reset values; a subsequent full frame decodes correctly. With CMD_ECHO_EN: one transmit pulse carrying tx_byte=cmd_check.

Source files
------------

// File: rtl/pump_probe_pkg.sv
// Shared constants and state encoding for the pump-probe host command path.
package pump_probe_pkg;

    localparam logic [7:0] CONT_DELAY     = 8'd0;
    localparam logic [7:0] CONT_PERIOD    = 8'd1;
    localparam logic [7:0] CONT_PUMP      = 8'd2;
    localparam logic [7:0] CONT_PROBE     = 8'd3;
    localparam logic [7:0] CONT_TOG_PUMP  = 8'd4;
    localparam logic [7:0] CONT_ATT       = 8'd5;
    localparam logic [7:0] CONT_READ_TEST = 8'd6;

    localparam int FRAME_LEN = 5;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        ECHO    = 2'd2
    } state_e;

endpackage

// File: rtl/uart_byte_timeout.sv
// Saturating inter-byte idle counter; expire strobes once the count reaches TIMEOUT_CYCLES-1.
module uart_byte_timeout #(
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en)
            cnt_d = '0;
        else if (cnt_q != LAST)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign expire = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_cmd_deframer.sv
// Assembles 4 data bytes + 1 control byte into a checksummed command word with valid/ready.
// Define CMD_ECHO_EN to echo the checksum back over the UART after each accepted command.
module uart_cmd_deframer
    import pump_probe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 120000,
    parameter int DATA_BYTES     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    received,
    input  logic [7:0]              rx_byte,
    input  logic                    recv_error,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [7:0]              cmd_code,
    output logic [8*DATA_BYTES-1:0] cmd_data,
    output logic [7:0]              cmd_check,
    output logic                    frame_err,
    output logic                    transmit,
    output logic [7:0]              tx_byte,
    input  logic                    is_transmitting
);

    localparam int IDX_W = $clog2(DATA_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]              sum_q, sum_d;
    logic [8*DATA_BYTES-1:0] data_q, data_d;
    logic [8*DATA_BYTES-1:0] cmd_data_q, cmd_data_d;
    logic [7:0]              cmd_code_q, cmd_code_d;
    logic [7:0]              cmd_check_q, cmd_check_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    received_q;
    logic                    byte_stb, tmo_en, tmo_expire;

`ifdef CMD_ECHO_EN
    logic [1:0] echo_ph_q, echo_ph_d;
    logic       transmit_q, transmit_d;
    logic [7:0] tx_byte_q, tx_byte_d;
`endif

    assign byte_stb = received & ~received_q;
    assign tmo_en   = (state_q == COLLECT) && (byte_idx_q != '0);

    uart_byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clr    (byte_stb),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        sum_d       = sum_q;
        data_d      = data_q;
        cmd_data_d  = cmd_data_q;
        cmd_code_d  = cmd_code_q;
        cmd_check_d = cmd_check_q;
        cmd_valid_d = cmd_valid_q;
        frame_err_d = 1'b0;
`ifdef CMD_ECHO_EN
        echo_ph_d   = echo_ph_q;
        transmit_d  = 1'b0;
        tx_byte_d   = tx_byte_q;
`endif
        case (state_q)
            COLLECT: begin
                // A framing error always swallows a coincident byte.
                if (recv_error) begin
                    if (byte_idx_q != '0) begin
                        byte_idx_d  = '0;
                        sum_d       = '0;
                        frame_err_d = 1'b1;
                    end
                end else if (byte_stb) begin
                    if (byte_idx_q != LAST_IDX) begin
                        for (int i = 0; i < DATA_BYTES; i++)
                            if (byte_idx_q == IDX_W'(i))
                                data_d[8*i +: 8] = rx_byte;
                        sum_d      = sum_q + rx_byte;
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end else begin
                        cmd_data_d  = data_q;
                        cmd_code_d  = rx_byte;
                        cmd_check_d = sum_q;
                        cmd_valid_d = 1'b1;
                        byte_idx_d  = '0;
                        sum_d       = '0;
                        state_d     = HOLD;
                    end
                end else if (tmo_expire) begin
                    byte_idx_d  = '0;
                    sum_d       = '0;
                    frame_err_d = 1'b1;
                end
            end
            HOLD: begin
                if (byte_stb)
                    frame_err_d = 1'b1;
                if (cmd_valid_q && cmd_ready) begin
                    cmd_valid_d = 1'b0;
`ifdef CMD_ECHO_EN
                    state_d     = ECHO;
                    echo_ph_d   = 2'd0;
`else
                    state_d     = COLLECT;
`endif
                end
            end
`ifdef CMD_ECHO_EN
            ECHO: begin
                if (byte_stb)
                    frame_err_d = 1'b1;
                case (echo_ph_q)
                    2'd0: if (!is_transmitting) begin
                        transmit_d = 1'b1;
                        tx_byte_d  = cmd_check_q;
                        echo_ph_d  = 2'd1;
                    end
                    2'd1: if (is_transmitting) echo_ph_d = 2'd2;
                    default: if (!is_transmitting) begin
                        echo_ph_d = 2'd0;
                        state_d   = COLLECT;
                    end
                endcase
            end
`endif
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            byte_idx_q  <= '0;
            sum_q       <= '0;
            data_q      <= '0;
            cmd_data_q  <= '0;
            cmd_code_q  <= '0;
            cmd_check_q <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            received_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            sum_q       <= sum_d;
            data_q      <= data_d;
            cmd_data_q  <= cmd_data_d;
            cmd_code_q  <= cmd_code_d;
            cmd_check_q <= cmd_check_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            received_q  <= received;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_check = cmd_check_q;
    assign frame_err = frame_err_q;

`ifdef CMD_ECHO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_ph_q  <= 2'd0;
            transmit_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            echo_ph_q  <= echo_ph_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
`else
    logic unused_is_transmitting;
    assign unused_is_transmitting = is_transmitting;
    assign transmit = 1'b0;
    assign tx_byte  = 8'd0;
`endif

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Directed bench for uart_cmd_deframer: framing, checksum wrap, timeout, overrun, reset and echo.
module tb_uart_cmd_deframer;
    import pump_probe_pkg::*;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        recv_error = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic [7:0]  cmd_check;
    logic        frame_err;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_transmitting = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int ferr_cnt = 0;
    int tx_cnt = 0;
    int hs_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] last_tx = 8'd0;

    uart_cmd_deframer #(.TIMEOUT_CYCLES(TMO), .DATA_BYTES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .received        (received),
        .rx_byte         (rx_byte),
        .recv_error      (recv_error),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_code        (cmd_code),
        .cmd_data        (cmd_data),
        .cmd_check       (cmd_check),
        .frame_err       (frame_err),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting)
    );

    always #5 clk = ~clk;

    // Simple UART transmitter stand-in: busy for 10 cycles after each request.
    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (transmit) begin
            tx_cnt++;
            last_tx  = tx_byte;
            busy_cnt = 10;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
        end
        is_transmitting = (busy_cnt != 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        received = 1'b1;
        rx_byte  = b;
        repeat (hold) tick();
        received = 1'b0;
        idle(2);
    endtask

    task automatic send_frame(input logic [31:0] d, input logic [7:0] code, input int hold);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], hold);
        send_byte(code, hold);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50 && !cmd_valid; i++) tick();
        chk(tag, {31'd0, cmd_valid}, 32'd1);
    endtask

    task automatic check_cmd(input string tag, input logic [31:0] d, input logic [7:0] code,
                             input logic [7:0] sum);
        chk({tag, "_data"}, cmd_data, d);
        chk({tag, "_code"}, {24'd0, cmd_code}, {24'd0, code});
        chk({tag, "_chk"}, {24'd0, cmd_check}, {24'd0, sum});
    endtask

    task automatic handshake(input string tag);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk({tag, "_vclr"}, {31'd0, cmd_valid}, 32'd0);
        hs_cnt++;
        idle(40);
    endtask

    initial begin
        idle(3);
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_data", cmd_data, 32'd0);
        chk("rst_code_chk", {16'd0, cmd_code, cmd_check}, 32'd0);
        chk("rst_err_tx", {22'd0, frame_err, transmit, tx_byte}, 32'd0);
        reset = 1'b0;
        idle(3);

        // Basic frame, held until ready.
        send_frame(32'h0000_2710, CONT_DELAY, 1);
        wait_valid("a_valid");
        check_cmd("a", 32'h0000_2710, 8'h00, 8'h37);
        idle(10);
        chk("a_hold", {31'd0, cmd_valid}, 32'd1);
        check_cmd("a_held", 32'h0000_2710, 8'h00, 8'h37);
        handshake("a");

        // Checksum wraps.
        send_frame(32'hFFFF_FFFF, CONT_ATT, 1);
        wait_valid("b_valid");
        check_cmd("b", 32'hFFFF_FFFF, 8'h05, 8'hFC);
        handshake("b");
        chk("no_err_yet", ferr_cnt, 0);

        // Partial frame times out, then a clean frame decodes from byte 0.
        send_byte(8'h55, 1);
        send_byte(8'h66, 1);
        idle(TMO + 20);
        chk("tmo_err", ferr_cnt, 1);
        chk("tmo_valid", {31'd0, cmd_valid}, 32'd0);
        send_frame(32'h0000_0001, CONT_TOG_PUMP, 1);
        wait_valid("c_valid");
        check_cmd("c", 32'h0000_0001, 8'h04, 8'h01);
        handshake("c");

        // Long received level counts once per byte.
        send_frame(32'h0000_2710, CONT_DELAY, 20);
        wait_valid("d_valid");
        check_cmd("d", 32'h0000_2710, 8'h00, 8'h37);
        handshake("d");
        chk("d_no_err", ferr_cnt, 1);

        // Overrun while holding.
        send_frame(32'h4433_2211, CONT_PROBE, 1);
        wait_valid("e_valid");
        send_byte(8'h99, 1);
        chk("ovr_err", ferr_cnt, 2);
        chk("ovr_valid", {31'd0, cmd_valid}, 32'd1);
        check_cmd("ovr_held", 32'h4433_2211, 8'h03, 8'hAA);
        handshake("e");
        send_frame(32'h0000_0002, CONT_PERIOD, 1);
        wait_valid("f_valid");
        check_cmd("f", 32'h0000_0002, 8'h01, 8'h02);
        handshake("f");

        // Reset mid-frame discards the partial frame.
        send_byte(8'hA1, 1);
        send_byte(8'hA2, 1);
        send_byte(8'hA3, 1);
        reset = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("mrst_data", cmd_data, 32'd0);
        chk("mrst_code_chk", {16'd0, cmd_code, cmd_check}, 32'd0);
        tick();
        reset = 1'b0;
        idle(2);
        send_frame(32'h0807_0605, CONT_PUMP, 1);
        wait_valid("g_valid");
        check_cmd("g", 32'h0807_0605, 8'h02, 8'h1A);
        handshake("g");

        // recv_error: ignored when idle, discards a partial frame otherwise.
        recv_error = 1'b1;
        tick();
        recv_error = 1'b0;
        idle(2);
        chk("rerr_idle", ferr_cnt, 2);
        send_byte(8'h77, 1);
        send_byte(8'h88, 1);
        recv_error = 1'b1;
        tick();
        recv_error = 1'b0;
        idle(2);
        chk("rerr_mid", ferr_cnt, 3);
        send_frame(32'h01EF_CDAB, CONT_READ_TEST, 1);
        wait_valid("h_valid");
        check_cmd("h", 32'h01EF_CDAB, 8'h06, 8'h68);
        handshake("h");

`ifdef CMD_ECHO_EN
        chk("echo_cnt", tx_cnt, hs_cnt);
        chk("echo_byte", {24'd0, last_tx}, 32'h68);
`else
        chk("no_tx", tx_cnt, 0);
`endif
        chk("err_total", ferr_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
